instruction_issue_queue: RTL and testbench
==========================================

INSTRUCTION_ISSUE_QUEUE -- requirements
Module: instruction_issue_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, entry count (power of two, 2..32).
REQ-002 The module SHALL have parameter PAYLOAD_W, default 64, opaque decoded-instruction payload width.
REQ-003 The module SHALL have parameter TAG_W, default 5, source/destination register tag width.
REQ-004 The module SHALL have parameter WAKE_PORTS, default 2, number of result-broadcast ports.
REQ-005 The module SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The module SHALL have port flush, input, 1, synchronous discard of all entries.
REQ-008 The module SHALL have ports enq_valid (input, 1) and enq_ready (output, 1), the decode-side handshake.
REQ-009 The module SHALL have port enq_payload, input, PAYLOAD_W, instruction payload.
REQ-010 The module SHALL have ports enq_src1_tag and enq_src2_tag (input, TAG_W) and enq_src1_rdy and enq_src2_rdy (input, 1), operand tags and their ready-at-dispatch flags.
REQ-011 The module SHALL have ports wake_valid (input, WAKE_PORTS) and wake_tag (input, WAKE_PORTS*TAG_W), result broadcasts; port p uses bits [p*TAG_W +: TAG_W].
REQ-012 The module SHALL have ports iss_valid (output, 1), iss_ready (input, 1) and iss_payload (output, PAYLOAD_W), the issue-side handshake.
REQ-013 The module SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.

Function
REQ-014 The queue SHALL be age-ordered and compacting: entry 0 is oldest, valid entries occupy indices 0..count-1 contiguously.
REQ-015 enq_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state.
REQ-016 An enqueue fires when enq_valid && enq_ready && !flush; the new entry is written at index count, or at count-1 if an issue fires in the same cycle.
REQ-017 Each entry SHALL store its payload, two tags and two ready bits; a ready bit sets when any wake_valid[p] has wake_tag[p] equal to that tag, and never clears.
REQ-018 A wake matching an enqueuing instruction's tag in the same cycle SHALL set that ready bit at write (no lost wakeup).
REQ-019 An entry is eligible when both ready bits are set; iss_valid SHALL be 1 when any eligible entry exists and flush is 0, and iss_payload SHALL be the payload of the lowest-index eligible entry.
REQ-020 A wake in cycle N SHALL make an entry eligible no earlier than cycle N+1 (registered ready bits).
REQ-021 An issue fires when iss_valid && iss_ready; the selected entry is removed, and all younger entries shift down by one at that edge.
REQ-022 iss_payload SHALL hold steady while iss_valid=1 and iss_ready=0, unless an older entry becomes eligible.
REQ-023 count SHALL update as +1 (enqueue only), -1 (issue only), or unchanged (both or neither).
REQ-024 With flush=1, all entries SHALL be invalidated at the edge, count SHALL become 0, and any enqueue or issue that cycle SHALL be dropped.
REQ-025 Full with a simultaneous issue SHALL NOT accept an enqueue that cycle (enq_ready stays 0).

Reset
REQ-026 On rst_n low, all entry valid and ready bits and count SHALL clear immediately; enq_ready=1 and iss_valid=0 while reset is held.
REQ-027 Payload and tag storage SHALL NOT require reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries, with no issue in the reset cycle.

Configuration
REQ-029 With macro IQ_ENQ_ISSUE_BYPASS_EN defined: when count==0, !flush, enq_valid=1 and both sources are ready (by flag or same-cycle wake), iss_valid=1 and iss_payload=enq_payload combinationally. If iss_ready=1, the instruction SHALL NOT be written into the queue and count stays 0.
REQ-030 With IQ_ENQ_ISSUE_BYPASS_EN undefined: minimum enqueue-to-issue latency SHALL be one cycle and iss_* SHALL depend only on registered state.

Verification
REQ-031 Reset then enqueue 3 ready instructions (payloads 0xA, 0xB, 0xC) with iss_ready=0 -> count=3, iss_payload=0xA; then iss_ready=1 for 3 cycles -> issues 0xA, 0xB, 0xC in order, count=0.
REQ-032 Enqueue an entry with src1_tag=7 not ready, then a ready entry 0xD -> 0xD issues first; wake_tag=7 in cycle N -> the first entry issues in cycle N+1.
REQ-033 Fill DEPTH=8 entries -> enq_ready=0 and an 9th enq_valid is held off; issue one -> enq_ready=1 next cycle, count=7.
REQ-034 Enqueue with src2_tag=3 not ready while wake_valid[1]=1 and wake_tag[1]=3 in the same cycle -> entry is eligible the next cycle.
REQ-035 With 5 entries, assert flush with enq_valid=1 and iss_ready=1 -> nothing issues, count=0 next cycle; toggle rst_n low with 4 entries -> count=0 immediately.
REQ-036 Bypass: with the macro defined, an empty queue, a ready enqueue of 0xE and iss_ready=1 -> 0xE issues the same cycle and count stays 0; with the macro undefined -> 0xE issues one cycle later.

Source files
------------

// File: rtl/instruction_issue_queue_if.sv
// instruction_issue_queue_if: decode-side enqueue and issue-side handshake bundle.
//   master: producer of enqueues / consumer of issues (decode + execute side)
//   slave : the issue queue itself
//   enq_valid/enq_ready, enq_payload, enq_src{1,2}_tag, enq_src{1,2}_rdy
//   iss_valid/iss_ready, iss_payload
interface instruction_issue_queue_if #(
   parameter int PAYLOAD_W = 64,
   parameter int TAG_W     = 5
);
   logic                 enq_valid;
   logic                 enq_ready;
   logic [PAYLOAD_W-1:0] enq_payload;
   logic [TAG_W-1:0]     enq_src1_tag;
   logic [TAG_W-1:0]     enq_src2_tag;
   logic                 enq_src1_rdy;
   logic                 enq_src2_rdy;
   logic                 iss_valid;
   logic                 iss_ready;
   logic [PAYLOAD_W-1:0] iss_payload;
   modport master (
      output enq_valid, enq_payload, enq_src1_tag, enq_src2_tag, enq_src1_rdy, enq_src2_rdy, iss_ready,
      input  enq_ready, iss_valid, iss_payload
   );
   modport slave (
      input  enq_valid, enq_payload, enq_src1_tag, enq_src2_tag, enq_src1_rdy, enq_src2_rdy, iss_ready,
      output enq_ready, iss_valid, iss_payload
   );
endinterface

// File: rtl/instruction_issue_queue.sv
// instruction_issue_queue: age-ordered compacting issue queue with tag wakeup.
//   clk, rst_n (async active-low), flush (sync discard)
//   wake_valid/wake_tag : result broadcasts, port p at wake_tag[p*TAG_W +: TAG_W]
//   count               : occupied entries
//   io (slave)          : enqueue and issue handshakes
//   Optional macro IQ_ENQ_ISSUE_BYPASS_EN: same-cycle enqueue-to-issue when empty.
module instruction_issue_queue #(
   parameter int DEPTH      = 8,
   parameter int PAYLOAD_W  = 64,
   parameter int TAG_W      = 5,
   parameter int WAKE_PORTS = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [WAKE_PORTS-1:0]       wake_valid,
   input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
   output logic [$clog2(DEPTH):0]      count,
   instruction_issue_queue_if.slave    io
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   logic [PAYLOAD_W-1:0] pl [DEPTH];
   logic [PAYLOAD_W-1:0] npl [DEPTH];
   logic [TAG_W-1:0]     t1 [DEPTH];
   logic [TAG_W-1:0]     t2 [DEPTH];
   logic [TAG_W-1:0]     nt1 [DEPTH];
   logic [TAG_W-1:0]     nt2 [DEPTH];
   logic [DEPTH-1:0]     r1, r2, nr1, nr2, h1, h2;
   logic                 e1, e2, any, iss_q, byp, enq_w, sh;
   logic [IW-1:0]        sel;
   logic [CW-1:0]        wi, ncnt;
   always_comb begin
      h1 = '0;
      h2 = '0;
      e1 = io.enq_src1_rdy;
      e2 = io.enq_src2_rdy;
      for (int p = 0; p < WAKE_PORTS; p++) begin
         if (wake_valid[p]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wake_tag[p*TAG_W +: TAG_W] == t1[i]) h1[i] = 1'b1;
               if (wake_tag[p*TAG_W +: TAG_W] == t2[i]) h2[i] = 1'b1;
            end
            if (wake_tag[p*TAG_W +: TAG_W] == io.enq_src1_tag) e1 = 1'b1;
            if (wake_tag[p*TAG_W +: TAG_W] == io.enq_src2_tag) e2 = 1'b1;
         end
      end
   end
   // Oldest eligible entry wins: scan from the top so the lowest index is kept.
   always_comb begin
      any = 1'b0;
      sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (CW'(i) < count && r1[i] && r2[i]) begin
            any = 1'b1;
            sel = IW'(i);
         end
      end
   end
   assign io.enq_ready = count < CW'(DEPTH);
   assign iss_q = any & ~flush & io.iss_ready;
`ifdef IQ_ENQ_ISSUE_BYPASS_EN
   assign byp            = count == '0 && !flush && io.enq_valid && e1 && e2;
   assign io.iss_valid   = (any & ~flush) | byp;
   assign io.iss_payload = any ? pl[sel] : io.enq_payload;
`else
   assign byp            = 1'b0;
   assign io.iss_valid   = any & ~flush;
   assign io.iss_payload = pl[sel];
`endif
   // A bypassed instruction that issues directly never occupies a slot.
   assign enq_w = io.enq_valid & io.enq_ready & ~flush & ~(byp & io.iss_ready);
   assign wi    = iss_q ? count - 1'b1 : count;
   assign ncnt  = flush ? '0 : count + CW'(enq_w) - CW'(iss_q);
   // Entries at or above the issued slot pull from their younger neighbour;
   // the wrapped read at the top index lands beyond the new count and is ignored.
   always_comb begin
      sh = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sh     = iss_q && IW'(i) >= sel;
         nr1[i] = sh ? r1[(i+1)%DEPTH] | h1[(i+1)%DEPTH] : r1[i] | h1[i];
         nr2[i] = sh ? r2[(i+1)%DEPTH] | h2[(i+1)%DEPTH] : r2[i] | h2[i];
         nt1[i] = sh ? t1[(i+1)%DEPTH] : t1[i];
         nt2[i] = sh ? t2[(i+1)%DEPTH] : t2[i];
         npl[i] = sh ? pl[(i+1)%DEPTH] : pl[i];
         if (enq_w && CW'(i) == wi) begin
            nr1[i] = e1;
            nr2[i] = e2;
            nt1[i] = io.enq_src1_tag;
            nt2[i] = io.enq_src2_tag;
            npl[i] = io.enq_payload;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         r1    <= '0;
         r2    <= '0;
      end else begin
         count <= ncnt;
         r1    <= nr1;
         r2    <= nr2;
      end
   end
   always_ff @(posedge clk) begin
      pl <= npl;
      t1 <= nt1;
      t2 <= nt2;
   end
endmodule

// File: tb/tb_instruction_issue_queue.sv
// tb_instruction_issue_queue: directed and random checks against a queue-based model.
module tb_instruction_issue_queue;
   localparam int DEPTH = 8;
   localparam int PW    = 64;
   localparam int TW    = 5;
   localparam int WP    = 2;
   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [WP-1:0]    wv = '0;
   logic [WP*TW-1:0] wt = '0;
   logic [3:0]       count;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [PW-1:0] pl;
      logic [TW-1:0] t1;
      logic [TW-1:0] t2;
      bit            r1;
      bit            r2;
   } ent_t;
   ent_t q[$];
   instruction_issue_queue_if #(.PAYLOAD_W(PW), .TAG_W(TW)) io ();
   instruction_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TAG_W(TW), .WAKE_PORTS(WP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .wake_valid (wv),
      .wake_tag   (wt),
      .count      (count),
      .io         (io)
   );
   always #5 clk = ~clk;
   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic bit whit(logic [TW-1:0] t);
      for (int p = 0; p < WP; p++) if (wv[p] && wt[p*TW +: TW] == t) return 1'b1;
      return 1'b0;
   endfunction
   task automatic idle();
      io.enq_valid    = 1'b0;
      io.enq_payload  = '0;
      io.enq_src1_tag = '0;
      io.enq_src2_tag = '0;
      io.enq_src1_rdy = 1'b0;
      io.enq_src2_rdy = 1'b0;
      io.iss_ready    = 1'b0;
      wv              = '0;
      wt              = '0;
      flush           = 1'b0;
   endtask
   task automatic enq(logic [PW-1:0] p, logic [TW-1:0] a, bit ar, logic [TW-1:0] b, bit br);
      io.enq_valid    = 1'b1;
      io.enq_payload  = p;
      io.enq_src1_tag = a;
      io.enq_src1_rdy = ar;
      io.enq_src2_tag = b;
      io.enq_src2_rdy = br;
   endtask
   // Compare all outputs against the model, then advance the model and the clock.
   task automatic tick();
      int   idx;
      bit   iv, byp, er, iss, en;
      logic [PW-1:0] ep;
      ent_t e;
      #1;
      idx = -1;
      foreach (q[i]) if (idx < 0 && q[i].r1 && q[i].r2) idx = i;
      er  = q.size() < DEPTH;
      byp = 1'b0;
`ifdef IQ_ENQ_ISSUE_BYPASS_EN
      byp = q.size() == 0 && !flush && io.enq_valid &&
            (io.enq_src1_rdy || whit(io.enq_src1_tag)) && (io.enq_src2_rdy || whit(io.enq_src2_tag));
`endif
      iv = (idx >= 0 && !flush) || byp;
      ep = idx >= 0 ? q[idx].pl : io.enq_payload;
      check("count", 64'(count), 64'(q.size()));
      check("enq_ready", 64'(io.enq_ready), 64'(er));
      check("iss_valid", 64'(io.iss_valid), 64'(iv));
      if (iv) check("iss_payload", io.iss_payload, ep);
      if (flush) q.delete();
      else begin
         iss = idx >= 0 && io.iss_ready;
         en  = io.enq_valid && er && !(byp && io.iss_ready);
         if (iss) q.delete(idx);
         foreach (q[i]) begin
            q[i].r1 = q[i].r1 | whit(q[i].t1);
            q[i].r2 = q[i].r2 | whit(q[i].t2);
         end
         if (en) begin
            e.pl = io.enq_payload;
            e.t1 = io.enq_src1_tag;
            e.t2 = io.enq_src2_tag;
            e.r1 = io.enq_src1_rdy | whit(io.enq_src1_tag);
            e.r2 = io.enq_src2_rdy | whit(io.enq_src2_tag);
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_enq_ready", 64'(io.enq_ready), 64'd1);
      check("rst_iss_valid", 64'(io.iss_valid), 64'd0);
      q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask
   initial begin
      idle();
      do_reset();
      // three ready instructions issue in age order
      enq(64'hA, 0, 1, 0, 1); tick();
      enq(64'hB, 0, 1, 0, 1); tick();
      enq(64'hC, 0, 1, 0, 1); tick();
      idle(); tick();
      check("r31_count", 64'(count), 64'd3);
      check("r31_head", io.iss_payload, 64'hA);
      io.iss_ready = 1'b1;
      repeat (3) tick();
      check("r31_drained", 64'(count), 64'd0);
      // blocked older entry is bypassed by a younger ready one, then woken
      idle(); enq(64'h100, 7, 0, 1, 1); tick();
      enq(64'hD, 1, 1, 2, 1); tick();
      idle();
      check("r32_first", io.iss_payload, 64'hD);
      io.iss_ready = 1'b1; tick();
      io.iss_ready = 1'b0; tick();
      wv = 2'b01; wt[4:0] = 5'd7; tick();
      idle();
      check("r32_woken_valid", 64'(io.iss_valid), 64'd1);
      check("r32_woken_payload", io.iss_payload, 64'h100);
      io.iss_ready = 1'b1; tick();
      // fill, hold off a ninth, then full-with-issue still refuses enqueue
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         enq(64'(32'h20 + i), 0, 1, 0, 1);
         tick();
      end
      check("r33_full_ready", 64'(io.enq_ready), 64'd0);
      enq(64'h99, 0, 1, 0, 1); tick();
      check("r33_held_count", 64'(count), 64'd8);
      io.iss_ready = 1'b1; tick();
      check("r33_after_issue_count", 64'(count), 64'd7);
      check("r33_after_issue_ready", 64'(io.enq_ready), 64'd1);
      idle(); io.iss_ready = 1'b1;
      repeat (7) tick();
      // same-cycle wake of an enqueuing operand is not lost
      idle(); enq(64'h34, 0, 1, 3, 0); wv = 2'b10; wt[9:5] = 5'd3; tick();
      idle();
      check("r34_valid", 64'(io.iss_valid), 64'd1);
      check("r34_payload", io.iss_payload, 64'h34);
      io.iss_ready = 1'b1; tick();
      // flush drops everything including same-cycle enqueue and issue
      idle();
      for (int i = 0; i < 5; i++) begin
         enq(64'(32'h50 + i), 0, 1, 0, 1);
         tick();
      end
      enq(64'h55, 0, 1, 0, 1); io.iss_ready = 1'b1; flush = 1'b1; tick();
      idle(); tick();
      check("r35_flush_count", 64'(count), 64'd0);
      for (int i = 0; i < 4; i++) begin
         enq(64'(32'h60 + i), 0, 1, 0, 1);
         tick();
      end
      idle();
      do_reset();
      // enqueue-to-issue latency on an empty queue
      idle(); enq(64'hE, 0, 1, 0, 1); io.iss_ready = 1'b1;
      #1;
`ifdef IQ_ENQ_ISSUE_BYPASS_EN
      check("r36_same_valid", 64'(io.iss_valid), 64'd1);
      check("r36_same_payload", io.iss_payload, 64'hE);
`else
      check("r36_same_valid", 64'(io.iss_valid), 64'd0);
`endif
      tick();
      idle(); io.iss_ready = 1'b1;
`ifdef IQ_ENQ_ISSUE_BYPASS_EN
      check("r36_next_count", 64'(count), 64'd0);
      check("r36_next_valid", 64'(io.iss_valid), 64'd0);
`else
      check("r36_next_valid", 64'(io.iss_valid), 64'd1);
      check("r36_next_payload", io.iss_payload, 64'hE);
`endif
      tick();
      // random traffic against the model
      repeat (400) begin
         idle();
         if ($urandom_range(2) != 0)
            enq({$urandom, $urandom}, 5'($urandom_range(7)), 1'($urandom_range(1)),
                5'($urandom_range(7)), 1'($urandom_range(1)));
         io.iss_ready = 1'($urandom_range(1));
         wv           = 2'($urandom_range(3));
         wt           = {5'($urandom_range(7)), 5'($urandom_range(7))};
         flush        = $urandom_range(39) == 0;
         tick();
      end
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
